dmx6_cap: RTL
=============

# dmx6_cap

Registered 1-to-6 capture demultiplexer: the inverse of the six-way select mux used in the TOM/DUPLO datapath. A stream of WIDTH-bit beats, each tagged with a 3-bit lane select, is steered into six holding registers. When all six lanes are filled the block presents them as one parallel frame and holds them until the consumer acknowledges. It sits between a serial producer (bus read sequencer, object fetch) and logic that consumes six words in parallel.

## Interface
- WIDTH, 16, bit width of each beat and each lane register
- sys_clk  in  1  system clock; all state changes on rising edge
- sys_reset  in  1  synchronous, active-high reset
- d  in  WIDTH  input beat
- d_valid  in  1  beat present on d
- sel  in  3  lane select for the beat (0..5 legal); unused when DMX6_AUTO_SEL_EN is defined
- d_ready  out  1  block accepts a beat this cycle
- q_0 .. q_5  out  WIDTH each  lane holding registers
- lane_valid  out  6  bit n set when lane n has been written in the current frame
- q_valid  out  1  all six lanes filled; frame presented
- q_ack  in  1  consumer takes the frame
- err_sel  out  1  one-cycle strobe: an accepted beat had sel of 6 or 7

## Operation
- Beat accepted when d_valid & d_ready.
- States: FILL, HOLD.
- FILL: d_ready = 1. An accepted beat with sel = n (0..5) loads q_n <= d and sets lane_valid[n]. An existing lane is overwritten; its lane_valid bit stays set. A beat with sel 6/7 is consumed and its data discarded; err_sel pulses; lanes are unchanged.
- FILL -> HOLD when an accepted beat makes lane_valid all ones. q_valid rises in the same edge.
- HOLD: d_ready = 0, q_0..q_5 frozen, q_valid = 1. q_ack -> FILL: lane_valid cleared to 0 and q_valid cleared in the same edge. q_0..q_5 keep their old values until rewritten.
- q_ack outside HOLD is ignored.
- Reset values: state FILL, q_0..q_5 = 0, lane_valid = 0, q_valid = 0, err_sel = 0. d_ready = 1 in the cycle after reset deasserts.
- Reset mid-frame or in HOLD discards all lane contents and status.

## Timing
- d_ready is combinational from state only (state == FILL). There is no path from d_valid, sel or q_ack to d_ready.
- All other outputs are registered.
- Latency: a beat accepted at edge k is visible on q_n and lane_valid at k. The frame completes on the sixth distinct-lane beat, with q_valid high from that edge.
- Back-to-back operation:
  - q_ack at edge k makes d_ready high from k.
  - A beat is accepted at edge k+1 at the earliest.
  - Minimum frame period is 7 cycles: 6 beats plus 1 ack.
- If q_ack is held high continuously, HOLD lasts exactly one cycle.
- err_sel is high for exactly one cycle per illegal accepted beat. It is never asserted in HOLD, because no beat is accepted there.

## Configuration
- DMX6_AUTO_SEL_EN defined:
  - sel is ignored and an internal 3-bit lane counter supplies the select.
  - The counter resets to 0, increments on each accepted beat and wraps 5 -> 0.
  - The counter resets to 0 on q_ack in HOLD.
  - err_sel is tied to 0.
  - The frame completes after exactly six beats.
- DMX6_AUTO_SEL_EN undefined: sel is used as described above.

## Structure
- Shared package dmx6_pkg holds:
  - LANES = 6
  - SEL_W = 3
  - the state enum dmx6_state_t {FILL, HOLD}
- Sub-module dmx6_lane: one WIDTH-bit register with load enable and synchronous clear, plus its lane_valid bit. It is instantiated six times; the select decode stays in the top.

## Test plan
- Reset, then sel 0..5 with d = 16'h1000..16'h1005 on consecutive cycles -> q_valid high after the sixth beat, q_n = 16'h100n, lane_valid = 6'b111111, d_ready = 0.
- In HOLD, drive d_valid with d = 16'hDEAD for 3 cycles, then pulse q_ack -> q_n unchanged, lane_valid = 0, q_valid = 0, d_ready = 1 from the next cycle.
- Write lane 2 with 16'hAAAA then 16'h5555, then fill the rest -> q_2 = 16'h5555, frame completes only when lanes 0,1,3,4,5 are written.
- Beat with sel = 7, d = 16'hBEEF -> err_sel one-cycle pulse, lane_valid and all q unchanged.
- Assert sys_reset after 4 lanes are filled -> all q = 0, lane_valid = 0, q_valid = 0. Six fresh beats then complete a frame normally.
- With DMX6_AUTO_SEL_EN: 12 beats 16'h0000..16'h000B with q_ack held high -> two frames, first frame q_n = n, second frame q_n = n + 6, sel ignored.

Source files
------------

// File: rtl/dmx6_pkg.sv
// dmx6_pkg: shared constants and types for the dmx6 capture demultiplexer.
//   LANES        number of holding lanes in one frame
//   SEL_W        width of the lane select
//   dmx6_state_t FILL (accepting beats) / HOLD (frame presented)
package dmx6_pkg;

    localparam int LANES = 6;
    localparam int SEL_W = 3;

    typedef enum logic [0:0] {
        FILL = 1'b0,
        HOLD = 1'b1
    } dmx6_state_t;

endpackage

// File: rtl/dmx6_lane.sv
// dmx6_lane: one lane holding register plus its "written this frame" flag.
// Ports:
//   clk        clock, rising edge
//   rst        synchronous reset: clears data and flag
//   load       capture d into q and set valid
//   clr_valid  clear valid only; q keeps its value until the next load
//   d          beat data
//   q          held data
//   valid      lane written in the current frame
module dmx6_lane
    import dmx6_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             clr_valid,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             valid
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q     <= '0;
            valid <= 1'b0;
        end else begin
            if (load) begin
                q <= d;
            end
            // load and clr_valid never coincide (load only in FILL, clear only
            // on ack in HOLD); load wins anyway so a lane is never lost.
            if (load) begin
                valid <= 1'b1;
            end else if (clr_valid) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/dmx6_cap.sv
// dmx6_cap: registered 1-to-6 capture demultiplexer. Beats tagged with a lane
// select are steered into six holding registers; once all six lanes are
// written the frame is presented (q_valid) and frozen until q_ack.
//
// Optional feature macro: DMX6_AUTO_SEL_EN -- when defined an internal lane
// counter replaces sel and err_sel is tied low.
//
// Ports:
//   sys_clk, sys_reset  clock and synchronous active-high reset
//   d, d_valid, sel     input beat, its valid, its lane select (0..5 legal)
//   d_ready             beat accepted this cycle when d_valid is also high
//   q_0 .. q_5          lane holding registers
//   lane_valid          per-lane "written this frame" flags
//   q_valid, q_ack      frame presented / consumer takes frame
//   err_sel             one-cycle strobe: accepted beat had sel 6 or 7
//   state_dbg           current FSM state for observation
//
// Handshake: a beat transfers on a rising edge where d_valid && d_ready.
// d_ready depends only on the state, never on d_valid, sel or q_ack.
// The frame is handed over on a rising edge where q_valid && q_ack.
module dmx6_cap
    import dmx6_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             sys_clk,
    input  logic             sys_reset,
    input  logic [WIDTH-1:0] d,
    input  logic             d_valid,
    input  logic [SEL_W-1:0] sel,
    output logic             d_ready,
    output logic [WIDTH-1:0] q_0,
    output logic [WIDTH-1:0] q_1,
    output logic [WIDTH-1:0] q_2,
    output logic [WIDTH-1:0] q_3,
    output logic [WIDTH-1:0] q_4,
    output logic [WIDTH-1:0] q_5,
    output logic [LANES-1:0] lane_valid,
    output logic             q_valid,
    input  logic             q_ack,
    output logic             err_sel,
    output dmx6_state_t      state_dbg
);

    dmx6_state_t      state;
    logic             accept;
    logic             release_frame;
    logic [SEL_W-1:0] lane_sel;
    logic [LANES-1:0] load_vec;
    logic             frame_full_next;
    logic [WIDTH-1:0] q_arr [LANES];

    assign d_ready       = (state == FILL);
    assign accept        = d_valid && d_ready;
    assign release_frame = (state == HOLD) && q_ack;
    assign state_dbg     = state;

`ifdef DMX6_AUTO_SEL_EN
    logic [SEL_W-1:0] lane_cnt;
    logic             unused_sel;

    assign unused_sel = ^sel;
    assign lane_sel   = lane_cnt;
    assign err_sel    = 1'b0;

    always_ff @(posedge sys_clk) begin
        if (sys_reset || release_frame) begin
            lane_cnt <= '0;
        end else if (accept) begin
            lane_cnt <= (lane_cnt == SEL_W'(LANES - 1)) ? '0 : lane_cnt + 1'b1;
        end
    end
`else
    assign lane_sel = sel;

    // Illegal selects are consumed (accepted) but only flagged.
    always_ff @(posedge sys_clk) begin
        if (sys_reset) begin
            err_sel <= 1'b0;
        end else begin
            err_sel <= accept && (lane_sel >= SEL_W'(LANES));
        end
    end
`endif

    always_comb begin
        load_vec = '0;
        for (int n = 0; n < LANES; n++) begin
            load_vec[n] = accept && (lane_sel == SEL_W'(n));
        end
    end

    // Frame completes on the beat that fills the last empty lane.
    assign frame_full_next = &(lane_valid | load_vec);

    for (genvar n = 0; n < LANES; n++) begin : g_lane
        dmx6_lane #(.WIDTH(WIDTH)) u_lane (
            .clk       (sys_clk),
            .rst       (sys_reset),
            .load      (load_vec[n]),
            .clr_valid (release_frame),
            .d         (d),
            .q         (q_arr[n]),
            .valid     (lane_valid[n])
        );
    end

    assign q_0 = q_arr[0];
    assign q_1 = q_arr[1];
    assign q_2 = q_arr[2];
    assign q_3 = q_arr[3];
    assign q_4 = q_arr[4];
    assign q_5 = q_arr[5];

    always_ff @(posedge sys_clk) begin
        if (sys_reset) begin
            state   <= FILL;
            q_valid <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    if (accept && frame_full_next) begin
                        state   <= HOLD;
                        q_valid <= 1'b1;
                    end
                end
                HOLD: begin
                    if (q_ack) begin
                        state   <= FILL;
                        q_valid <= 1'b0;
                    end
                end
                default: begin
                    state   <= FILL;
                    q_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
